// File: rtl/pong_pkg.sv
// Shared definitions for the Pong game sequencer: match states, winner
// codes and the default winning score.
package pong_pkg;

  // Match state encoding, also exported on the debug/display state port.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    PLAY   = 3'd2,
    PAUSED = 3'd3,
    OVER   = 3'd4
  } state_t;

  // Match result codes driven on the winner port.
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // Score a player has to reach to win outright.
  localparam int DEFAULT_WIN_SCORE = 7;

  // Result when the match clock runs out: higher score wins, equal is a draw.
  function automatic logic [1:0] timeout_winner(input logic [3:0] p1,
                                                input logic [3:0] p2);
    logic [1:0] result;
    if (p1 > p2) begin
      result = WIN_P1;
    end else if (p2 > p1) begin
      result = WIN_P2;
    end else begin
      result = WIN_DRAW;
    end
    return result;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous push button followed by a
// rising-edge detector. A held button produces exactly one event pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic evt
);

  logic sync1_q;
  logic sync1_d;
  logic sync2_q;
  logic sync2_d;
  logic hist_q;
  logic hist_d;

  // Next values of the synchronizer chain and the edge-history register.
  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
  end

  // Synchronizer and history flops; all clear so no event fires out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  // Event is high for the single cycle where the synchronized level first rises.
  assign evt = sync2_q & ~hist_q;

endmodule

// File: rtl/game_state_controller.sv
// Pong match sequencer. Cleans up the start and pause buttons and runs the
// idle / serve / play / pause / game-over state machine on top of the scores
// and countdown produced by the ball-control stage.
module game_state_controller
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = DEFAULT_WIN_SCORE,
  parameter int SERVE_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic [3:0] scoreP1,
  input  logic [3:0] scoreP2,
  input  logic [5:0] timer_minutes,
  input  logic [5:0] timer_seconds,
  output logic       game_active,
  output logic       game_over,
  output logic       new_game,
  output logic [1:0] winner,
  output logic [2:0] state
);

  // A one-cycle serve still needs a one-bit counter.
  localparam int              CNT_W      = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]       WIN_LIMIT  = 4'(WIN_SCORE);

  logic start_evt;
  logic pause_evt;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] serve_cnt_q;
  logic [CNT_W-1:0] serve_cnt_d;
  logic [1:0]       winner_q;
  logic [1:0]       winner_d;
  logic             new_game_q;
  logic             new_game_d;
  logic             game_active_q;
  logic             game_active_d;
  logic             game_over_q;
  logic             game_over_d;
  logic [3:0]       prev_p1_q;
  logic [3:0]       prev_p1_d;
  logic [3:0]       prev_p2_q;
  logic [3:0]       prev_p2_d;

  logic p1_wins;
  logic p2_wins;
  logic timer_zero;
  logic point_scored;

  btn_sync_edge u_start_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_in  (btn_start),
    .evt     (start_evt)
  );

  btn_sync_edge u_pause_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_in  (btn_pause),
    .evt     (pause_evt)
  );

  // Match conditions derived from the ball-control inputs.
  always_comb begin
    p1_wins      = (scoreP1 >= WIN_LIMIT);
    p2_wins      = (scoreP2 >= WIN_LIMIT);
    timer_zero   = (timer_minutes == 6'd0) && (timer_seconds == 6'd0);
    point_scored = (scoreP1 != prev_p1_q) || (scoreP2 != prev_p2_q);
  end

  // Next-state logic: match sequencing, serve counting and score tracking.
  // In PLAY a win beats timer expiry, which beats a point, which beats pause.
  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    winner_d    = winner_q;
    new_game_d  = 1'b0;
    prev_p1_d   = prev_p1_q;
    prev_p2_d   = prev_p2_q;

    case (state_q)
      IDLE, OVER: begin
        // Previous scores are zeroed so the ball stage's score clear is not a point.
        if (start_evt) begin
          state_d     = SERVE;
          new_game_d  = 1'b1;
          winner_d    = WIN_NONE;
          serve_cnt_d = '0;
          prev_p1_d   = 4'd0;
          prev_p2_d   = 4'd0;
        end
      end

      SERVE: begin
        if (serve_cnt_q == SERVE_LAST) begin
          serve_cnt_d = '0;
          state_d     = PLAY;
        end else begin
          serve_cnt_d = serve_cnt_q + CNT_ONE;
        end
      end

      PLAY: begin
        prev_p1_d = scoreP1;
        prev_p2_d = scoreP2;
        if (p1_wins) begin
          winner_d = WIN_P1;
          state_d  = OVER;
        end else if (p2_wins) begin
          winner_d = WIN_P2;
          state_d  = OVER;
        end else if (timer_zero) begin
          winner_d = timeout_winner(scoreP1, scoreP2);
          state_d  = OVER;
        end else if (point_scored) begin
          serve_cnt_d = '0;
          state_d     = SERVE;
        end else if (pause_evt) begin
          state_d = PAUSED;
        end
      end

      PAUSED: begin
        if (pause_evt) begin
          state_d = PLAY;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    game_active_d = (state_d == PLAY);
    game_over_d   = (state_d == OVER);
  end

  // State machine register with its registered outputs and score history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      serve_cnt_q   <= '0;
      winner_q      <= WIN_NONE;
      new_game_q    <= 1'b0;
      game_active_q <= 1'b0;
      game_over_q   <= 1'b0;
      prev_p1_q     <= 4'd0;
      prev_p2_q     <= 4'd0;
    end else begin
      state_q       <= state_d;
      serve_cnt_q   <= serve_cnt_d;
      winner_q      <= winner_d;
      new_game_q    <= new_game_d;
      game_active_q <= game_active_d;
      game_over_q   <= game_over_d;
      prev_p1_q     <= prev_p1_d;
      prev_p2_q     <= prev_p2_d;
    end
  end

  assign game_active = game_active_q;
  assign game_over   = game_over_q;
  assign new_game    = new_game_q;
  assign winner      = winner_q;
  assign state       = state_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Self-checking bench for game_state_controller: directed match scenarios
// followed by random button/score/timer activity, all compared every cycle
// against a behavioural model of the match rules.
module tb_game_state_controller;

  localparam int WIN_SCORE    = 7;
  localparam int SERVE_CYCLES = 8;

  localparam int MODE_IDLE   = 0;
  localparam int MODE_SERVE  = 1;
  localparam int MODE_PLAY   = 2;
  localparam int MODE_PAUSED = 3;
  localparam int MODE_OVER   = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_pause = 1'b0;
  logic [3:0] scoreP1 = 4'd0;
  logic [3:0] scoreP2 = 4'd0;
  logic [5:0] timer_minutes = 6'd5;
  logic [5:0] timer_seconds = 6'd0;
  logic       game_active;
  logic       game_over;
  logic       new_game;
  logic [1:0] winner;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  // Reference model: mode, result, and time-stamped serve tracking.
  int         m_mode;
  logic [1:0] m_winner;
  logic       m_new_game;
  int         m_cycle;
  int         m_serve_start;
  int         m_last1;
  int         m_last2;
  logic [2:0] m_start_hist;
  logic [2:0] m_pause_hist;

  game_state_controller #(
    .WIN_SCORE    (WIN_SCORE),
    .SERVE_CYCLES (SERVE_CYCLES)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .btn_start     (btn_start),
    .btn_pause     (btn_pause),
    .scoreP1       (scoreP1),
    .scoreP2       (scoreP2),
    .timer_minutes (timer_minutes),
    .timer_seconds (timer_seconds),
    .game_active   (game_active),
    .game_over     (game_over),
    .new_game      (new_game),
    .winner        (winner),
    .state         (state)
  );

  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] observed,
                           input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic m_reset();
    m_mode        = MODE_IDLE;
    m_winner      = 2'b00;
    m_new_game    = 1'b0;
    m_serve_start = 0;
    m_last1       = 0;
    m_last2       = 0;
    m_start_hist  = 3'b000;
    m_pause_hist  = 3'b000;
  endtask

  task automatic m_begin_match();
    m_mode        = MODE_SERVE;
    m_serve_start = m_cycle;
    m_new_game    = 1'b1;
    m_winner      = 2'b00;
    m_last1       = 0;
    m_last2       = 0;
  endtask

  // One clock edge of the match rules, using the inputs present at that edge.
  task automatic m_edge();
    logic sev;
    logic pev;
    logic point;
    int   p1;
    int   p2;
    sev = m_start_hist[1] & ~m_start_hist[2];
    pev = m_pause_hist[1] & ~m_pause_hist[2];
    m_start_hist = {m_start_hist[1:0], btn_start};
    m_pause_hist = {m_pause_hist[1:0], btn_pause};
    m_cycle++;
    m_new_game = 1'b0;
    p1 = int'(scoreP1);
    p2 = int'(scoreP2);
    case (m_mode)
      MODE_IDLE, MODE_OVER: if (sev) m_begin_match();
      MODE_SERVE: if (m_cycle - m_serve_start == SERVE_CYCLES) m_mode = MODE_PLAY;
      MODE_PLAY: begin
        point   = (p1 != m_last1) || (p2 != m_last2);
        m_last1 = p1;
        m_last2 = p2;
        if (p1 >= WIN_SCORE) begin
          m_winner = 2'b01;
          m_mode   = MODE_OVER;
        end else if (p2 >= WIN_SCORE) begin
          m_winner = 2'b10;
          m_mode   = MODE_OVER;
        end else if (timer_minutes == 6'd0 && timer_seconds == 6'd0) begin
          m_winner = (p1 > p2) ? 2'b01 : ((p2 > p1) ? 2'b10 : 2'b11);
          m_mode   = MODE_OVER;
        end else if (point) begin
          m_mode        = MODE_SERVE;
          m_serve_start = m_cycle;
        end else if (pev) begin
          m_mode = MODE_PAUSED;
        end
      end
      MODE_PAUSED: if (pev) m_mode = MODE_PLAY;
      default: m_mode = MODE_IDLE;
    endcase
  endtask

  task automatic checkOutput(input string tag);
    check_val({tag, "_state"}, {29'd0, state}, 32'(m_mode));
    check_val({tag, "_active"}, {31'd0, game_active}, {31'd0, m_mode == MODE_PLAY});
    check_val({tag, "_over"}, {31'd0, game_over}, {31'd0, m_mode == MODE_OVER});
    check_val({tag, "_newgame"}, {31'd0, new_game}, {31'd0, m_new_game});
    check_val({tag, "_winner"}, {30'd0, winner}, {30'd0, m_winner});
  endtask

  // Advance one clock, step the model, then compare away from the edge.
  task automatic tick();
    @(posedge clk);
    if (reset_n) m_edge();
    #1;
    checkOutput("cycle");
  endtask

  task automatic wait_for_state(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && int'(state) != target; i++) tick();
    check_val(tag, {29'd0, state}, 32'(target));
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    tick();
    btn_start = 1'b0;
  endtask

  task automatic press_pause();
    btn_pause = 1'b1;
    tick();
    btn_pause = 1'b0;
  endtask

  // Starts a new match from IDLE/OVER and plays the ball stage's score clear.
  task automatic restart_match(input string tag);
    press_start();
    wait_for_state(MODE_SERVE, 6, {tag, "_serve"});
    scoreP1 = 4'd0;
    scoreP2 = 4'd0;
    wait_for_state(MODE_PLAY, 20, {tag, "_play"});
  endtask

  // Random button, score and timer activity, with the occasional reset.
  task automatic applyStimulus();
    if (new_game) begin
      scoreP1 = 4'd0;
      scoreP2 = 4'd0;
    end
    if ($urandom_range(0, 99) < 6) btn_start = ~btn_start;
    if ($urandom_range(0, 99) < 6) btn_pause = ~btn_pause;
    if ($urandom_range(0, 99) < 3) begin
      if ($urandom_range(0, 1) == 0) begin
        if (scoreP1 < 4'd15) scoreP1 = scoreP1 + 4'd1;
      end else begin
        if (scoreP2 < 4'd15) scoreP2 = scoreP2 + 4'd1;
      end
    end
    if (timer_minutes == 6'd0 && timer_seconds == 6'd0) begin
      timer_minutes = 6'd4;
      timer_seconds = 6'($urandom_range(1, 59));
    end else if ($urandom_range(0, 199) == 0) begin
      timer_minutes = 6'd0;
      timer_seconds = 6'd0;
    end
    if ($urandom_range(0, 499) == 0) begin
      reset_n = 1'b0;
      #1;
      m_reset();
      checkOutput("rand_reset");
      tick();
      reset_n = 1'b1;
    end
  endtask

  initial begin
    int ng;
    int serve_seen;
    int found;

    m_cycle = 0;
    m_reset();

    // Reset state.
    repeat (3) tick();
    check_val("reset_state", {29'd0, state}, 32'd0);
    check_val("reset_winner", {30'd0, winner}, 32'd0);
    check_val("reset_active", {31'd0, game_active}, 32'd0);
    reset_n = 1'b1;
    repeat (3) tick();
    check_val("idle_wait", {29'd0, state}, 32'd0);

    // Long start press: one new_game pulse and an exact serve hold.
    ng = 0;
    serve_seen = 0;
    btn_start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (new_game) ng++;
      if (state == 3'd1) serve_seen++;
    end
    btn_start = 1'b0;
    for (int i = 0; i < 20 && state != 3'd2; i++) begin
      tick();
      if (new_game) ng++;
      if (state == 3'd1) serve_seen++;
    end
    check_val("start_ng_pulses", 32'(ng), 32'd1);
    check_val("serve_hold_cycles", 32'(serve_seen), 32'(SERVE_CYCLES));
    check_val("first_play_active", {31'd0, game_active}, 32'd1);

    // Point by P1: back to serve at once, no new_game.
    scoreP1 = 4'd2;
    tick();
    wait_for_state(MODE_PLAY, 20, "p1_first_point_play");
    scoreP1 = 4'd3;
    tick();
    check_val("point_active_drop", {31'd0, game_active}, 32'd0);
    check_val("point_state_serve", {29'd0, state}, 32'd1);
    check_val("point_no_newgame", {31'd0, new_game}, 32'd0);
    serve_seen = 1;
    for (int i = 0; i < 20 && state != 3'd2; i++) begin
      tick();
      if (state == 3'd1) serve_seen++;
    end
    check_val("point_serve_cycles", 32'(serve_seen), 32'(SERVE_CYCLES));

    // P2 reaches the winning score.
    scoreP2 = 4'd6;
    tick();
    wait_for_state(MODE_PLAY, 20, "p2_six_play");
    scoreP2 = 4'd7;
    tick();
    check_val("p2_win_state", {29'd0, state}, 32'd4);
    check_val("p2_win_over", {31'd0, game_over}, 32'd1);
    check_val("p2_win_code", {30'd0, winner}, 32'd2);
    repeat (5) tick();
    check_val("p2_win_held", {30'd0, winner}, 32'd2);
    press_start();
    found = 0;
    for (int i = 0; i < 6 && found == 0; i++) begin
      tick();
      if (new_game) found = 1;
    end
    check_val("over_restart_ng", 32'(found), 32'd1);
    check_val("over_restart_winner", {30'd0, winner}, 32'd0);
    scoreP1 = 4'd0;
    scoreP2 = 4'd0;
    wait_for_state(MODE_PLAY, 20, "restart_play");

    // Timer expiry with a tie.
    scoreP1 = 4'd4;
    scoreP2 = 4'd4;
    tick();
    wait_for_state(MODE_PLAY, 20, "tie_play");
    timer_minutes = 6'd0;
    timer_seconds = 6'd0;
    tick();
    check_val("timeout_tie_state", {29'd0, state}, 32'd4);
    check_val("timeout_tie_winner", {30'd0, winner}, 32'd3);
    timer_minutes = 6'd5;
    restart_match("tie_restart");

    // Timer expiry with P1 ahead.
    scoreP1 = 4'd5;
    scoreP2 = 4'd3;
    tick();
    wait_for_state(MODE_PLAY, 20, "lead_play");
    timer_minutes = 6'd0;
    tick();
    check_val("timeout_lead_winner", {30'd0, winner}, 32'd1);
    timer_minutes = 6'd5;
    restart_match("lead_restart");

    // Pause and resume; start ignored while paused.
    press_pause();
    tick();
    check_val("pause_latency", {29'd0, state}, 32'd2);
    tick();
    check_val("paused_state", {29'd0, state}, 32'd3);
    check_val("paused_inactive", {31'd0, game_active}, 32'd0);
    press_start();
    repeat (4) tick();
    check_val("start_in_pause", {29'd0, state}, 32'd3);
    press_pause();
    repeat (2) tick();
    check_val("unpause_state", {29'd0, state}, 32'd2);

    // Pause during serve has no effect.
    scoreP1 = 4'd1;
    tick();
    press_pause();
    repeat (3) tick();
    check_val("pause_in_serve", {29'd0, state}, 32'd1);
    wait_for_state(MODE_PLAY, 20, "serve_pause_play");
    repeat (4) tick();
    check_val("serve_pause_dropped", {29'd0, state}, 32'd2);

    // Reset in the middle of a serve with the counter at 5.
    scoreP1 = 4'd2;
    tick();
    repeat (5) tick();
    check_val("mid_serve_state", {29'd0, state}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    m_reset();
    checkOutput("mid_reset");
    check_val("mid_reset_state", {29'd0, state}, 32'd0);
    check_val("mid_reset_active", {31'd0, game_active}, 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    scoreP1 = 4'd0;
    scoreP2 = 4'd0;
    repeat (12) tick();
    check_val("needs_new_start", {29'd0, state}, 32'd0);

    // Random activity against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
